// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared widths, queue depth and the write request type
package writeback_arbiter_pkg;
    localparam int XLEN     = 64;
    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int LQ_DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU, load, reservation, hazard and register-bank write signals
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_rd;
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic            hazard;
    logic            wb_regwrite;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  rsv_valid, rsv_rd, chk_rs1, chk_rs2,
        output ld_ready, hazard, wb_regwrite, wb_rd, wb_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output rsv_valid, rsv_rd, chk_rs1, chk_rs2,
        input  ld_ready, hazard, wb_regwrite, wb_rd, wb_data
    );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: circular-buffer FIFO with wrapping pointers and an occupancy count
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rp];

    // storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop) rp <= rp + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load results onto the register-bank write port
module writeback_arbiter
    import writeback_arbiter_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    writeback_arbiter_if.slave  bus
);
    localparam int CW = $clog2(LQ_DEPTH + 1);

    wb_req_t         alu_req, ld_req, head, sel, wb_q;
    logic            empty, full, pop, push, bypass, ld_acc, ld_ready;
    logic            sel_valid, ld_sel, regwrite_q;
    logic [CW-1:0]   count;
    logic [NREG-1:0] pending, set_m, clr_m;

    assign alu_req  = '{rd: bus.alu_rd, data: bus.alu_data};
    assign ld_req   = '{rd: bus.ld_rd, data: bus.ld_data};
    assign ld_ready = (count < CW'(LQ_DEPTH)) && !rst;

    wb_fifo #(.DEPTH(LQ_DEPTH), .W($bits(wb_req_t))) u_fifo (
        .clk(clk), .rst(rst), .push(push), .din(ld_req), .pop(pop),
        .dout(head), .full(full), .empty(empty), .count(count)
    );

    // ALU first, then queued loads in order, then a bypassed load when the queue is empty
    always_comb begin
        ld_acc    = bus.ld_valid && ld_ready;
        pop       = !bus.alu_valid && !empty;
        bypass    = !bus.alu_valid && empty && ld_acc;
        push      = ld_acc && !bypass && !full;
        sel_valid = bus.alu_valid || pop || bypass;
        ld_sel    = pop || bypass;
        sel       = bus.alu_valid ? alu_req : pop ? head : ld_req;
        set_m     = (bus.rsv_valid && bus.rsv_rd != '0) ? NREG'(1) << bus.rsv_rd : '0;
        clr_m     = ld_sel ? NREG'(1) << sel.rd : '0;
    end

    // write port register and pending-load scoreboard; a new reservation beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            wb_q       <= '0;
            pending    <= '0;
        end else begin
            regwrite_q <= sel_valid && sel.rd != '0;
            if (sel_valid && sel.rd != '0) wb_q <= sel;
            pending <= (pending & ~clr_m) | set_m;
        end
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.wb_regwrite = regwrite_q;
    assign bus.wb_rd       = wb_q.rd;
    assign bus.wb_data     = wb_q.data;
    assign bus.hazard      = !rst && (pending[bus.chk_rs1] | pending[bus.chk_rs2]);
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random stimulus against a queue-based reference model
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    typedef struct {
        bit          rst;
        bit          alu_v;
        logic [4:0]  alu_rd;
        logic [63:0] alu_d;
        bit          ld_v;
        logic [4:0]  ld_rd;
        logic [63:0] ld_d;
        bit          rsv_v;
        logic [4:0]  rsv_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stim_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } ld_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [63:0] d;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ld_t  lq[$];
    exp_t exp_q[$];
    bit [31:0] pend = '0;

    writeback_arbiter_if bus();

    writeback_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at cycle %0d", n, a, e, cyc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // one cycle: drive, check combinational outputs, advance the model, queue expected writes
    task automatic step(input stim_t s, output bit acc);
        bit   exp_ready, exp_haz, have_w, from_ld, byp;
        ld_t  w;
        @(negedge clk);
        rst           = s.rst;
        bus.alu_valid = s.alu_v;
        bus.alu_rd    = s.alu_rd;
        bus.alu_data  = s.alu_d;
        bus.ld_valid  = s.ld_v;
        bus.ld_rd     = s.ld_rd;
        bus.ld_data   = s.ld_d;
        bus.rsv_valid = s.rsv_v;
        bus.rsv_rd    = s.rsv_rd;
        bus.chk_rs1   = s.rs1;
        bus.chk_rs2   = s.rs2;
        cyc++;
        #1;
        exp_ready = !s.rst && lq.size() < LQ_DEPTH;
        exp_haz   = !s.rst && (pend[s.rs1] || pend[s.rs2]);
        chk("ld_ready", 64'(bus.ld_ready), 64'(exp_ready));
        chk("hazard", 64'(bus.hazard), 64'(exp_haz));
        acc = s.ld_v && exp_ready;
        if (s.rst) begin
            lq.delete();
            pend = '0;
        end else begin
            have_w = 0; from_ld = 0; byp = 0;
            if (s.alu_v) begin
                w = '{s.alu_rd, s.alu_d}; have_w = 1;
            end else if (lq.size() > 0) begin
                w = lq.pop_front(); have_w = 1; from_ld = 1;
            end else if (acc) begin
                w = '{s.ld_rd, s.ld_d}; have_w = 1; from_ld = 1; byp = 1;
            end
            if (acc && !byp) lq.push_back('{s.ld_rd, s.ld_d});
            if (have_w && w.rd != 0) begin
                exp_q.push_back('{cyc, w.rd, w.d});
                if (from_ld) pend[w.rd] = 0;
            end
            if (s.rsv_v && s.rsv_rd != 0) pend[s.rsv_rd] = 1;
        end
    endtask

    // monitor: every registered write must match the oldest expectation for this cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.wb_regwrite) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    chk("spurious_write", 64'(bus.wb_rd), 64'hFFFF);
                end else begin
                    chk("wb_rd", 64'(bus.wb_rd), 64'(exp_q[0].rd));
                    chk("wb_data", bus.wb_data, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("missing_write_rd", 64'(bus.wb_regwrite), 64'(exp_q[0].rd) | 64'h100);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        ld_t   cur;
        bit    a, have_ld;

        // reset with a load offered
        s = idle(); s.rst = 1; s.ld_v = 1; s.ld_rd = 4; s.ld_d = 64'h44;
        step(s, a); step(s, a);
        s = idle();
        step(s, a);
        chk("reset_wb_rd", 64'(bus.wb_rd), 64'h0);
        chk("reset_wb_data", bus.wb_data, 64'h0);

        // ALU only
        s = idle(); s.alu_v = 1; s.alu_rd = 5; s.alu_d = 64'hDEAD_BEEF;
        step(s, a);
        s = idle(); step(s, a); step(s, a);

        // contention: ALU wins, load follows from the queue
        s = idle(); s.alu_v = 1; s.alu_rd = 3; s.alu_d = 64'h11;
        s.ld_v = 1; s.ld_rd = 7; s.ld_d = 64'h22;
        step(s, a);
        s = idle(); step(s, a); step(s, a);

        // backpressure: four ALU cycles while loads 8, 9, 10 are offered
        have_ld = 1; cur = '{5'd8, 64'h808};
        for (int i = 0; i < 10; i++) begin
            s = idle();
            if (i < 4) begin s.alu_v = 1; s.alu_rd = 5'(20 + i); s.alu_d = 64'(i); end
            s.ld_v = have_ld; s.ld_rd = cur.rd; s.ld_d = cur.d;
            step(s, a);
            if (a) begin
                have_ld = cur.rd != 10;
                cur = '{cur.rd + 5'd1, cur.d + 64'h101};
            end
        end

        // scoreboard: reserve 12, hold hazard, clear by load, then re-reserve during writeback
        s = idle(); s.rsv_v = 1; s.rsv_rd = 12; step(s, a);
        s = idle(); s.rs1 = 12; step(s, a); step(s, a);
        s.ld_v = 1; s.ld_rd = 12; s.ld_d = 64'hC; step(s, a);
        s = idle(); s.rs1 = 12; step(s, a); step(s, a);
        s.rsv_v = 1; s.rsv_rd = 12; step(s, a);
        s = idle(); s.rs2 = 12; s.ld_v = 1; s.ld_rd = 12; s.ld_d = 64'hCC; s.rsv_v = 1; s.rsv_rd = 12;
        step(s, a);
        s = idle(); s.rs2 = 12; step(s, a); step(s, a);

        // x0: writes dropped, reservation ignored
        s = idle(); s.alu_v = 1; s.rsv_v = 1; step(s, a);
        s = idle(); s.ld_v = 1; s.ld_d = 64'h99; step(s, a);
        s = idle(); step(s, a); step(s, a);

        // random traffic with occasional reset
        have_ld = 0;
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst = $urandom_range(0, 249) == 0;
            s.alu_v = $urandom_range(0, 99) < 50;
            s.alu_rd = 5'($urandom_range(0, 15));
            s.alu_d = {$urandom, $urandom};
            if (!have_ld && $urandom_range(0, 1) == 1) begin
                have_ld = 1;
                cur = '{5'($urandom_range(0, 15)), {$urandom, $urandom}};
            end
            s.ld_v = have_ld && $urandom_range(0, 3) != 0;
            s.ld_rd = cur.rd; s.ld_d = cur.d;
            s.rsv_v = $urandom_range(0, 99) < 25;
            s.rsv_rd = 5'($urandom_range(0, 15));
            s.rs1 = 5'($urandom_range(0, 15));
            s.rs2 = 5'($urandom_range(0, 31));
            step(s, a);
            if (a) have_ld = 0;
        end

        s = idle();
        for (int i = 0; i < 6; i++) step(s, a);
        chk("drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side front end of the 64-bit, 32-entry register bank; drives its single write port: regwrite, destination register index, and write data.
- Merges two result sources into that one port: the single-cycle ALU path and the variable-latency load-response path.
- Buffers load results while the ALU owns the port.
- Keeps a per-register pending-load scoreboard; decode uses it to stall on read-after-load hazards.

Parameters:
- XLEN, 64, data width.
- NREG, 32, number of architectural registers.
- AW, 5, register index width (log2 NREG).
- LQ_DEPTH, 2, load result queue entries (power of two, at least 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU result present this cycle; always accepted, no ready
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load response valid
- ld_rd  in  AW  load destination register
- ld_data  in  XLEN  load data
- ld_ready  out  1  load response accepted when ld_valid && ld_ready
- rsv_valid  in  1  decode issues a load; reserve rsv_rd
- rsv_rd  in  AW  register to mark pending
- chk_rs1  in  AW  decode source register 1
- chk_rs2  in  AW  decode source register 2
- hazard  out  1  either source register has a pending load
- wb_regwrite  out  1  register bank write enable
- wb_rd  out  AW  register bank write index
- wb_data  out  XLEN  register bank write data

Behaviour:
- Reset: synchronous, active-high. While rst is high and on the cycle after it: wb_regwrite=0, wb_rd=0, wb_data=0, queue empty, all pending bits clear, hazard=0. ld_ready=0 while rst is high. Loads queued at reset are dropped.
- Output register: wb_* are registered. A write selected in cycle N appears in cycle N+1 for exactly one cycle. Otherwise wb_regwrite=0; wb_rd and wb_data hold their last values.
- Priority per cycle:
  1. alu_valid → select the ALU result.
  2. Else queue not empty → pop the head and select it.
  3. Else (queue empty) ld_valid && ld_ready → bypass; select the load directly at latency 1; nothing is pushed.
- Push: an accepted load not taken by bypass is pushed at the queue tail.
- Simultaneous push and pop in one cycle is legal; count is unchanged.
- ld_ready = (count < LQ_DEPTH) && !rst. It uses the current count only, with no credit for a same-cycle pop.
- FIFO: circular buffer with wrapping read and write pointers and a count register. Order is strictly preserved.
- Register x0: a selected write with rd=0 yields wb_regwrite=0. It still consumes its slot: the ALU cycle or the queue pop.
- Scoreboard: pending[NREG-1:1]; pending[0] is constant 0.
  - Set on rsv_valid with rsv_rd≠0, effective next cycle.
  - Cleared on the edge that registers a load write (from queue or bypass) to that register.
  - Set and clear on the same register in the same cycle: set wins.
  - ALU writes never clear pending bits.
- hazard = pending[chk_rs1] | pending[chk_rs2]. Combinational from registered state; no same-cycle forwarding of rsv_valid.
- Load starvation: back-to-back alu_valid starves the queue. Once the queue fills, ld_ready=0 applies backpressure. This is accepted.

Decomposition:
- Shared package holds XLEN, NREG, AW, and the typedef wb_req_t {rd, data}, used by the queue entries and the output register.
- One natural sub-module: wb_fifo (parameterised depth/width FIFO with push, pop, full, empty, count).
- Arbitration, bypass, scoreboard and output register stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with ld_valid=1 → wb_regwrite=0, ld_ready=0, hazard=0 throughout; ld_ready=1 the cycle after rst deasserts.
- ALU only: alu_valid, rd=5, data=0xDEAD_BEEF in cycle N → cycle N+1 shows wb_regwrite=1, wb_rd=5, wb_data=0xDEADBEEF; cycle N+2 shows wb_regwrite=0.
- Contention: alu_valid (rd=3, 0x11) and ld_valid (rd=7, 0x22) in the same cycle → ALU write next cycle, load write the cycle after; queue count 1 then 0.
- Backpressure: alu_valid held for 4 cycles while loads (rd 8, 9, 10) are offered → ld_ready=0 after two accepts; once alu_valid drops, writes to 8 then 9 in order; rd=10 accepted once ready returns.
- Scoreboard: rsv_valid rd=12, then chk_rs1=12 → hazard=1 until the load to 12 writes back, hazard=0 the next cycle. Same-cycle re-reserve of 12 during writeback → hazard remains 1.
- x0: ALU and load results to rd=0 → wb_regwrite never asserts; rsv_rd=0 never raises hazard.
